// File: rtl/reflet_mem_arbiter_if.sv
// Bus bundle between two RAM requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; the master modport is the requesters'/RAM side.
interface reflet_mem_arbiter_if #(
  parameter int wordsize = 16
);
  logic                req0;
  logic [wordsize-1:0] addr0;
  logic [wordsize-1:0] wdata0;
  logic                we0;
  logic                ack0;
  logic [wordsize-1:0] rdata0;

  logic                req1;
  logic [wordsize-1:0] addr1;
  logic [wordsize-1:0] wdata1;
  logic                we1;
  logic                ack1;
  logic [wordsize-1:0] rdata1;

  logic [1:0]          grant;
  logic [wordsize-1:0] ram_addr;
  logic [wordsize-1:0] ram_data_out;
  logic                ram_write_en;
  logic [wordsize-1:0] ram_data_in;

  modport slave (
    input  req0, addr0, wdata0, we0,
    input  req1, addr1, wdata1, we1,
    input  ram_data_in,
    output ack0, rdata0, ack1, rdata1,
    output grant, ram_addr, ram_data_out, ram_write_en
  );

  modport master (
    output req0, addr0, wdata0, we0,
    output req1, addr1, wdata1, we1,
    output ram_data_in,
    input  ack0, rdata0, ack1, rdata1,
    input  grant, ram_addr, ram_data_out, ram_write_en
  );
endinterface

// File: rtl/reflet_mem_arbiter.sv
// Two-port arbiter onto one single-port RAM; round-robin ties, or port 0 priority with REFLET_MEM_ARBITER_FIXED_PRIORITY_EN.
// Latency: ack is high ram_latency+2 cycles after the request is sampled in IDLE.
// Backpressure: req is held until a one-cycle ack; enable=0 freezes every state bit and output.
module reflet_mem_arbiter #(
  parameter int wordsize    = 16,
  parameter int ram_latency = 1
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  enable,
  reflet_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          grant_q;
  logic                last_grant;
  logic                we_q;
  logic [3:0]          cnt;
  logic [wordsize-1:0] addr_q, wdata_q, rdata0_q, rdata1_q;
  logic                start;
  logic                pick1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
`ifdef REFLET_MEM_ARBITER_FIXED_PRIORITY_EN
    pick1     = !bus.req0;
`else
    // On a tie, the port that did not win last time takes the slot.
    pick1     = bus.req1 && (!bus.req0 || !last_grant);
`endif
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= 2'b00;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q     <= pick1 ? bus.addr1  : bus.addr0;
            wdata_q    <= pick1 ? bus.wdata1 : bus.wdata0;
            we_q       <= pick1 ? bus.we1    : bus.we0;
            grant_q    <= pick1 ? 2'b10      : 2'b01;
            last_grant <= pick1;
          end
        end
        ACCESS: cnt <= 4'(ram_latency - 1);
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!we_q) begin
              if (grant_q[0]) rdata0_q <= bus.ram_data_in;
              if (grant_q[1]) rdata1_q <= bus.ram_data_in;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    grant_q <= 2'b00;
        default: ;
      endcase
    end
  end

  // Address and write data stay on the RAM bus after the access; only the strobe qualifies a write.
  assign bus.ram_addr     = addr_q;
  assign bus.ram_data_out = wdata_q;
  assign bus.ram_write_en = (state == ACCESS) && we_q;
  assign bus.grant        = grant_q;
  assign bus.ack0         = (state == DONE) && grant_q[0];
  assign bus.ack1         = (state == DONE) && grant_q[1];
  assign bus.rdata0       = rdata0_q;
  assign bus.rdata1       = rdata1_q;

endmodule

// File: doc/reflet_mem_arbiter.md
Name: reflet_mem_arbiter

Overview:
- Shares one single-port RAM between two requesters: port 0 is the CPU address unit, port 1 is a secondary master such as a DMA or debug loader.
- Each port uses a req/ack handshake. The arbiter latches the winning request, drives the RAM for one access slot, waits a fixed RAM latency, then returns read data with a one-cycle ack.
- Sits between the requesters' address/data buses and the RAM, replacing the direct addr/data_out/write_en connection.

Parameters:
- wordsize, 16, width of addresses and data on all ports.
- ram_latency, 1, cycles from RAM address presentation to valid ram_data_in; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset is asynchronous and active-high.
- enable  in  1  global clock enable; when low, all state and outputs hold.
- req0  in  1  port 0 access request; held high until ack0.
- addr0  in  wordsize  port 0 address.
- wdata0  in  wordsize  port 0 write data.
- we0  in  1  port 0 write (1) / read (0).
- ack0  out  1  one-cycle pulse; port 0 access complete.
- rdata0  out  wordsize  port 0 read data; valid while ack0=1.
- req1, addr1, wdata1, we1, ack1, rdata1: same as port 0, for port 1.
- grant  out  2  one-hot owner of the RAM slot; 00 when idle.
- ram_addr  out  wordsize  RAM address.
- ram_data_out  out  wordsize  RAM write data.
- ram_write_en  out  1  RAM write strobe.
- ram_data_in  in  wordsize  RAM read data.

Behaviour:
- Reset values: state=IDLE, grant=00, ack0=ack1=0, rdata0=rdata1=0, ram_addr=0, ram_data_out=0, ram_write_en=0, last_grant=1 (so port 0 wins the first tie), wait counter=0.
- All updates occur on posedge clk with enable=1. With enable=0, everything freezes, including mid-wait.
- FSM states:
  - IDLE: sample req0/req1.
    - Neither high: stay in IDLE.
    - One high: grant that port.
    - Both high: grant the port not equal to last_grant.
    - On grant: latch addr/wdata/we into ram_addr/ram_data_out/a write flag, set grant one-hot, set last_grant, go to ACCESS.
  - ACCESS: exactly 1 cycle. ram_write_en = latched we. Load counter with ram_latency-1. Go to WAIT.
  - WAIT: ram_write_en=0; ram_addr held. Decrement the counter each cycle; when counter==0, capture ram_data_in into the granted port's rdata (reads only; writes leave rdata unchanged), go to DONE.
  - DONE: ack of the granted port=1 for exactly this cycle; grant cleared at exit. Go to IDLE.
- Latency: req sampled high in IDLE at edge N → ACCESS during cycle N+1 → ack high during cycle N+2+ram_latency. With ram_latency=1, ack is high 3 cycles after req is sampled.
- Requester rule: deassert req on the cycle after ack. The arbiter does not sample req in DONE, so a req still high in the IDLE cycle after DONE is a new request.
- Back-to-back: two simultaneous persistent requests alternate grants (0,1,0,1…). No port waits more than one access slot.
- addr/wdata/we changes after the grant edge are ignored; the latched values are used.
- ram_data_out and ram_addr hold their last values in IDLE; only ram_write_en qualifies a write.
- At most one of ack0/ack1 is high in any cycle; grant is never 11.
- Asserting reset mid-operation immediately returns all outputs to reset values, drops any in-flight write strobe, and loses the access; no ack is issued.

Optional Feature:
- REFLET_MEM_ARBITER_FIXED_PRIORITY_EN
  - Defined: port 0 always wins simultaneous requests; last_grant is unused. Port 1 can starve under continuous port-0 traffic.
  - Undefined: round-robin tie-break as described in Behaviour.

Test Plan:
- Single read: ram_latency=1, RAM preloaded 0x1234 at 0x0040, req0 addr0=0x0040 we0=0 → ram_addr=0x0040, ack0 pulse 3 cycles after req, rdata0=0x1234, ack1 never high.
- Single write: req1 addr1=0x0010 wdata1=0xBEEF we1=1 → ram_write_en high exactly 1 cycle with ram_addr=0x0010, ram_data_out=0xBEEF; ack1 pulse; readback via port 0 returns 0xBEEF.
- Contention: req0 and req1 both high and held after each ack → grant sequence 01,10,01,10 after reset (port 0 first); each port's ack arrives every other slot. With the macro defined: port 0 is always served.
- Latency sweep: ram_latency=4, read 0x00AA → ack exactly 6 cycles after req; RAM model data changed before the capture cycle is reflected, changes after it are not.
- Enable stall: deassert enable for 5 cycles during WAIT → no outputs change; ack arrives 5 cycles later than nominal with correct data.
- Reset mid-write: assert reset during ACCESS of a write → ram_write_en falls immediately, grant=00, no ack; after release, a fresh req0 completes normally.
